// File: rtl/svc_axi_sram_if_rd.sv
// ---------------------------------------------------------------------------
// svc_axi_sram_if_rd
//
// Purpose:
//   Read half of the AXI4-to-SRAM bridge. The block accepts one AR burst at a
//   time and turns it into one SRAM read command per beat. Each command
//   carries {id, last} metadata. The SRAM controller returns that metadata
//   with the read data, so the R channel is a plain combinational
//   pass-through of the SRAM response port and needs no tracking state here.
//
// Ports:
//   clk, rst_n            - clock; synchronous active-low reset
//   s_axi_ar*             - AXI read address channel (slave side)
//   s_axi_r*              - AXI read data channel (slave side)
//   sram_rd_cmd_*         - SRAM read command: word address + {id, last}
//   sram_rd_resp_*        - SRAM read response: data + {id, last}
// ---------------------------------------------------------------------------
module svc_axi_sram_if_rd #(
    parameter int  AXI_ADDR_WIDTH = 20,
    parameter int  AXI_DATA_WIDTH = 16,
    parameter int  AXI_ID_WIDTH   = 4,
    localparam int LSB            = $clog2(AXI_DATA_WIDTH) - 3,
    localparam int SAW            = AXI_ADDR_WIDTH - LSB,
    localparam int MW             = AXI_ID_WIDTH + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,

    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,

    output logic                      sram_rd_cmd_valid,
    input  logic                      sram_rd_cmd_ready,
    output logic [SAW-1:0]            sram_rd_cmd_addr,
    output logic [MW-1:0]             sram_rd_cmd_meta,

    input  logic                      sram_rd_resp_valid,
    output logic                      sram_rd_resp_ready,
    input  logic [AXI_DATA_WIDTH-1:0] sram_rd_resp_data,
    input  logic [MW-1:0]             sram_rd_resp_meta
);

    localparam int AW = AXI_ADDR_WIDTH;
    localparam int IW = AXI_ID_WIDTH;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t          state;
    logic [AW-1:0]   cur_addr;
    logic [IW-1:0]   id_q;
    logic [7:0]      len_q;
    logic [2:0]      size_q;
    logic [1:0]      burst_q;
    logic [7:0]      beat_cnt;
    logic            cmd_valid_q;

    logic [AW-1:0]   step;
    logic [AW-1:0]   incr_addr;
    logic [AW-1:0]   wrap_mask;
    logic            wrap_ok;
    logic [AW-1:0]   next_addr;
    logic            last_beat;
    logic            cmd_fire;

    // A new burst can only be taken while no burst is in flight. arready is
    // derived straight from the state register, so it rises the cycle after
    // the final command is accepted, never in the same cycle.
    assign s_axi_arready = (state == IDLE);

    assign last_beat = (beat_cnt == 8'd0);
    assign cmd_fire  = cmd_valid_q && sram_rd_cmd_ready;

    // Address step and wrap boundary. Both are powers of two, so the
    // multiply (len+1)*step reduces to a shift. Only 2/4/8/16-beat wraps are
    // legal; any other length falls back to incrementing.
    assign step      = AW'(1) << size_q;
    assign incr_addr = cur_addr + step;
    assign wrap_mask = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
    assign wrap_ok   = (len_q == 8'd1) || (len_q == 8'd3) ||
                       (len_q == 8'd7) || (len_q == 8'd15);

    // Next beat address. Reserved burst type 11 is treated as INCR.
    always_comb begin
        next_addr = incr_addr;
        case (burst_q)
            2'b00: next_addr = cur_addr;
            2'b10: begin
                if (wrap_ok) begin
                    next_addr = (cur_addr & ~wrap_mask) | (incr_addr & wrap_mask);
                end
            end
            default: next_addr = incr_addr;
        endcase
    end

    // Burst sequencer. The AR handshake loads the burst and raises
    // cmd_valid on the same edge, so the first command appears one cycle
    // later. Command fields are only updated on an accepted command, which
    // keeps them stable while the SRAM side stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_valid_q <= 1'b0;
            beat_cnt    <= 8'd0;
            cur_addr    <= '0;
            id_q        <= '0;
            len_q       <= 8'd0;
            size_q      <= 3'd0;
            burst_q     <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axi_arvalid) begin
                        id_q        <= s_axi_arid;
                        cur_addr    <= s_axi_araddr;
                        len_q       <= s_axi_arlen;
                        size_q      <= s_axi_arsize;
                        burst_q     <= s_axi_arburst;
                        beat_cnt    <= s_axi_arlen;
                        cmd_valid_q <= 1'b1;
                        state       <= BURST;
                    end
                end
                BURST: begin
                    if (cmd_fire) begin
                        if (last_beat) begin
                            cmd_valid_q <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt - 8'd1;
                            cur_addr <= next_addr;
                        end
                    end
                end
                default: begin
                    cmd_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

    assign sram_rd_cmd_valid = cmd_valid_q;
    assign sram_rd_cmd_addr  = cur_addr[AW-1:LSB];
    assign sram_rd_cmd_meta  = {id_q, last_beat};

    // R channel: the SRAM response already carries id and last, so it is
    // forwarded unchanged with no buffering and no link to the command side.
    assign s_axi_rvalid       = sram_rd_resp_valid;
    assign sram_rd_resp_ready = s_axi_rready;
    assign s_axi_rdata        = sram_rd_resp_data;
    assign s_axi_rid          = sram_rd_resp_meta[MW-1:1];
    assign s_axi_rlast        = sram_rd_resp_meta[0];
    assign s_axi_rresp        = 2'b00;

endmodule

// File: tb/tb_svc_axi_sram_if_rd.sv
// ---------------------------------------------------------------------------
// tb_svc_axi_sram_if_rd
//
// Directed bench for svc_axi_sram_if_rd using the default parameters
// (AW=20, DW=16, IW=4, so word address = byte address >> 1). Inputs are
// driven and outputs sampled around the falling clock edge. Every expected
// value is a hand-computed constant.
// ---------------------------------------------------------------------------
module tb_svc_axi_sram_if_rd;

    localparam int AW  = 20;
    localparam int DW  = 16;
    localparam int IW  = 4;
    localparam int SAW = 19;
    localparam int MW  = 5;

    logic            clk;
    logic            rst_n;
    logic            s_axi_arvalid;
    logic            s_axi_arready;
    logic [IW-1:0]   s_axi_arid;
    logic [AW-1:0]   s_axi_araddr;
    logic [7:0]      s_axi_arlen;
    logic [2:0]      s_axi_arsize;
    logic [1:0]      s_axi_arburst;
    logic            s_axi_rvalid;
    logic            s_axi_rready;
    logic [IW-1:0]   s_axi_rid;
    logic [DW-1:0]   s_axi_rdata;
    logic [1:0]      s_axi_rresp;
    logic            s_axi_rlast;
    logic            sram_rd_cmd_valid;
    logic            sram_rd_cmd_ready;
    logic [SAW-1:0]  sram_rd_cmd_addr;
    logic [MW-1:0]   sram_rd_cmd_meta;
    logic            sram_rd_resp_valid;
    logic            sram_rd_resp_ready;
    logic [DW-1:0]   sram_rd_resp_data;
    logic [MW-1:0]   sram_rd_resp_meta;

    int assertCount = 0;
    int failCount   = 0;

    logic [31:0] expWord [0:15];

    svc_axi_sram_if_rd #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .AXI_ID_WIDTH   (IW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .s_axi_arvalid      (s_axi_arvalid),
        .s_axi_arready      (s_axi_arready),
        .s_axi_arid         (s_axi_arid),
        .s_axi_araddr       (s_axi_araddr),
        .s_axi_arlen        (s_axi_arlen),
        .s_axi_arsize       (s_axi_arsize),
        .s_axi_arburst      (s_axi_arburst),
        .s_axi_rvalid       (s_axi_rvalid),
        .s_axi_rready       (s_axi_rready),
        .s_axi_rid          (s_axi_rid),
        .s_axi_rdata        (s_axi_rdata),
        .s_axi_rresp        (s_axi_rresp),
        .s_axi_rlast        (s_axi_rlast),
        .sram_rd_cmd_valid  (sram_rd_cmd_valid),
        .sram_rd_cmd_ready  (sram_rd_cmd_ready),
        .sram_rd_cmd_addr   (sram_rd_cmd_addr),
        .sram_rd_cmd_meta   (sram_rd_cmd_meta),
        .sram_rd_resp_valid (sram_rd_resp_valid),
        .sram_rd_resp_ready (sram_rd_resp_ready),
        .sram_rd_resp_data  (sram_rd_resp_data),
        .sram_rd_resp_meta  (sram_rd_resp_meta)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one AR request for a single cycle. Called at a falling edge
    // with the DUT idle; returns at the falling edge after the handshake,
    // when the first command is already visible.
    task automatic applyStimulus(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                                 input logic [7:0] len, input logic [2:0] size,
                                 input logic [1:0] burst);
        s_axi_arvalid = 1'b1;
        s_axi_arid    = id;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arsize  = size;
        s_axi_arburst = burst;
        @(negedge clk);
        s_axi_arvalid = 1'b0;
    endtask

    // Walks a burst with cmd_ready held high, checking one command per
    // cycle against expWord, then checks the return to idle.
    task automatic drainBurst(input string tag, input int nBeats, input logic [IW-1:0] id);
        for (int i = 0; i < nBeats; i++) begin
            checkOutput({tag, "_valid"}, 32'(sram_rd_cmd_valid), 32'd1);
            checkOutput({tag, "_addr"}, 32'(sram_rd_cmd_addr), expWord[i]);
            checkOutput({tag, "_meta"}, 32'(sram_rd_cmd_meta),
                        32'({id, (i == nBeats - 1) ? 1'b1 : 1'b0}));
            checkOutput({tag, "_arready"}, 32'(s_axi_arready), 32'd0);
            @(negedge clk);
        end
        checkOutput({tag, "_done_valid"}, 32'(sram_rd_cmd_valid), 32'd0);
        checkOutput({tag, "_done_arready"}, 32'(s_axi_arready), 32'd1);
    endtask

    initial begin
        int beat;
        logic hs;
        logic [7:0] pattern;

        rst_n              = 1'b0;
        s_axi_arvalid      = 1'b0;
        s_axi_arid         = '0;
        s_axi_araddr       = '0;
        s_axi_arlen        = '0;
        s_axi_arsize       = '0;
        s_axi_arburst      = '0;
        s_axi_rready       = 1'b0;
        sram_rd_cmd_ready  = 1'b0;
        sram_rd_resp_valid = 1'b0;
        sram_rd_resp_data  = '0;
        sram_rd_resp_meta  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_cmd_valid", 32'(sram_rd_cmd_valid), 32'd0);
        checkOutput("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        checkOutput("rst_arready", 32'(s_axi_arready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single beat, command stalled for three cycles
        applyStimulus(4'hB, 20'h0A000, 8'd0, 3'd1, 2'b01);
        for (int i = 0; i < 4; i++) begin
            checkOutput("stall_valid", 32'(sram_rd_cmd_valid), 32'd1);
            checkOutput("stall_meta", 32'(sram_rd_cmd_meta), 32'h17);
            checkOutput("stall_addr", 32'(sram_rd_cmd_addr), 32'h05000);
            checkOutput("stall_arready", 32'(s_axi_arready), 32'd0);
            if (i < 3) @(negedge clk);
        end
        sram_rd_cmd_ready = 1'b1;
        @(negedge clk);
        checkOutput("single_done_valid", 32'(sram_rd_cmd_valid), 32'd0);
        checkOutput("single_done_arready", 32'(s_axi_arready), 32'd1);

        // INCR len=3 size=1 from 0x0100
        expWord[0] = 32'h080; expWord[1] = 32'h081; expWord[2] = 32'h082; expWord[3] = 32'h083;
        applyStimulus(4'h5, 20'h00100, 8'd3, 3'd1, 2'b01);
        drainBurst("incr", 4, 4'h5);

        // WRAP len=3 size=1 from 0x0104 wraps inside the 8-byte block at 0x100
        expWord[0] = 32'h082; expWord[1] = 32'h083; expWord[2] = 32'h080; expWord[3] = 32'h081;
        applyStimulus(4'h6, 20'h00104, 8'd3, 3'd1, 2'b10);
        drainBurst("wrap", 4, 4'h6);

        // WRAP with illegal length 3 beats behaves as INCR
        expWord[0] = 32'h082; expWord[1] = 32'h083; expWord[2] = 32'h084;
        applyStimulus(4'h7, 20'h00104, 8'd2, 3'd1, 2'b10);
        drainBurst("wrapbad", 3, 4'h7);

        // FIXED len=2 keeps the same address
        expWord[0] = 32'h100; expWord[1] = 32'h100; expWord[2] = 32'h100;
        applyStimulus(4'h2, 20'h00200, 8'd2, 3'd1, 2'b00);
        drainBurst("fixed", 3, 4'h2);

        // INCR rolls over the top of the address space
        expWord[0] = 32'h7FFFF; expWord[1] = 32'h00000;
        applyStimulus(4'h9, 20'hFFFFE, 8'd1, 3'd1, 2'b01);
        drainBurst("incrwrap", 2, 4'h9);

        // INCR with 4-byte step: word address advances by 2
        expWord[0] = 32'h010; expWord[1] = 32'h012;
        applyStimulus(4'hC, 20'h00020, 8'd1, 3'd2, 2'b01);
        drainBurst("size2", 2, 4'hC);

        // AR held high across the last command handshake: accepted one cycle late
        s_axi_arvalid = 1'b1;
        s_axi_arid    = 4'h1;
        s_axi_araddr  = 20'h00010;
        s_axi_arlen   = 8'd0;
        s_axi_arsize  = 3'd1;
        s_axi_arburst = 2'b01;
        @(negedge clk);
        checkOutput("b2b_first_valid", 32'(sram_rd_cmd_valid), 32'd1);
        checkOutput("b2b_first_arready", 32'(s_axi_arready), 32'd0);
        @(negedge clk);
        checkOutput("b2b_gap_valid", 32'(sram_rd_cmd_valid), 32'd0);
        checkOutput("b2b_gap_arready", 32'(s_axi_arready), 32'd1);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        checkOutput("b2b_second_valid", 32'(sram_rd_cmd_valid), 32'd1);
        checkOutput("b2b_second_addr", 32'(sram_rd_cmd_addr), 32'h008);
        @(negedge clk);
        checkOutput("b2b_end_valid", 32'(sram_rd_cmd_valid), 32'd0);

        // Backpressure: cmd_ready follows a fixed pattern during a 4-beat burst
        sram_rd_cmd_ready = 1'b0;
        pattern = 8'b1001_0110;
        beat = 0;
        applyStimulus(4'hD, 20'h00300, 8'd3, 3'd1, 2'b01);
        for (int cyc = 0; cyc < 40; cyc++) begin
            hs = 1'b0;
            if (sram_rd_cmd_valid) begin
                checkOutput("bp_addr", 32'(sram_rd_cmd_addr), 32'h180 + 32'(beat));
                checkOutput("bp_meta", 32'(sram_rd_cmd_meta),
                            32'({4'hD, (beat == 3) ? 1'b1 : 1'b0}));
                sram_rd_cmd_ready = pattern[cyc % 8];
                hs = sram_rd_cmd_ready;
            end else begin
                sram_rd_cmd_ready = 1'b0;
            end
            @(negedge clk);
            if (hs) beat++;
            if (beat >= 4) break;
        end
        checkOutput("bp_beats", 32'(beat), 32'd4);
        sram_rd_cmd_ready = 1'b1;
        repeat (2) begin
            checkOutput("bp_idle_valid", 32'(sram_rd_cmd_valid), 32'd0);
            @(negedge clk);
        end

        // Response pass-through
        sram_rd_resp_valid = 1'b1;
        sram_rd_resp_data  = 16'h1234;
        sram_rd_resp_meta  = {4'h3, 1'b1};
        s_axi_rready       = 1'b0;
        #1;
        checkOutput("r_valid", 32'(s_axi_rvalid), 32'd1);
        checkOutput("r_id", 32'(s_axi_rid), 32'h3);
        checkOutput("r_last", 32'(s_axi_rlast), 32'd1);
        checkOutput("r_data", 32'(s_axi_rdata), 32'h1234);
        checkOutput("r_resp", 32'(s_axi_rresp), 32'd0);
        checkOutput("r_resp_ready0", 32'(sram_rd_resp_ready), 32'd0);
        s_axi_rready = 1'b1;
        #1;
        checkOutput("r_resp_ready1", 32'(sram_rd_resp_ready), 32'd1);
        sram_rd_resp_data = 16'hBEEF;
        sram_rd_resp_meta = {4'hA, 1'b0};
        #1;
        checkOutput("r_id2", 32'(s_axi_rid), 32'hA);
        checkOutput("r_last2", 32'(s_axi_rlast), 32'd0);
        checkOutput("r_data2", 32'(s_axi_rdata), 32'hBEEF);
        sram_rd_resp_valid = 1'b0;
        #1;
        checkOutput("r_valid_off", 32'(s_axi_rvalid), 32'd0);
        @(negedge clk);

        // Reset in the middle of a stalled burst abandons it
        sram_rd_cmd_ready = 1'b0;
        applyStimulus(4'h4, 20'h00400, 8'd3, 3'd1, 2'b01);
        checkOutput("mid_rst_pre_valid", 32'(sram_rd_cmd_valid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_valid", 32'(sram_rd_cmd_valid), 32'd0);
        checkOutput("mid_rst_arready", 32'(s_axi_arready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_valid", 32'(sram_rd_cmd_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
